// File: rtl/id_operand_stage.sv
// Decode-side operand fetch: latches one decoded instruction, resolves operands from RF/bypass, interlocks on unready producers.
// Optional interlock-cycle counter enabled by defining OPFETCH_STALL_CNT_EN.
module id_operand_stage #(
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_allowin,
  input  logic [4:0]           in_raddr1,
  input  logic [4:0]           in_raddr2,
  input  logic                 in_ren1,
  input  logic                 in_ren2,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [4:0]           rf_raddr1,
  output logic [4:0]           rf_raddr2,
  input  logic [31:0]          rf_rdata1,
  input  logic [31:0]          rf_rdata2,
  output logic [4:0]           by_raddr1,
  output logic [4:0]           by_raddr2,
  output logic                 by_ren1,
  output logic                 by_ren2,
  input  logic [31:0]          by_rdata1,
  input  logic [31:0]          by_rdata2,
  input  logic [1:0]           by_sel,
  input  logic                 exe_valid,
  input  logic                 exe_wen,
  input  logic                 exe_ready,
  input  logic [4:0]           exe_waddr,
  input  logic                 mem_valid,
  input  logic                 mem_wen,
  input  logic                 mem_ready,
  input  logic [4:0]           mem_waddr,
  output logic                 out_valid,
  input  logic                 out_allowin,
  output logic [31:0]          out_src1,
  output logic [31:0]          out_src2,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [31:0]          stall_cnt
);

  logic                 dsVld_p0;
  logic [4:0]           raddr1_p0;
  logic [4:0]           raddr2_p0;
  logic                 ren1_p0;
  logic                 ren2_p0;
  logic [PAYLOAD_W-1:0] payload_p0;
  logic                 hazard1;
  logic                 hazard2;
  logic                 stall;
  logic                 readyGo;

  // An unready EXE match stalls regardless of MEM, so a stale MEM value is never forwarded.
  function automatic logic srcHazard(
    input logic ren, input logic [4:0] raddr,
    input logic eV, input logic eW, input logic eR, input logic [4:0] eA,
    input logic mV, input logic mW, input logic mR, input logic [4:0] mA
  );
    return ren && (raddr != 5'd0) &&
           ((eV && eW && (eA == raddr) && !eR) ||
            (mV && mW && (mA == raddr) && !mR));
  endfunction

  function automatic logic [31:0] selOperand(
    input logic [4:0] raddr, input logic sel,
    input logic [31:0] byData, input logic [31:0] rfData
  );
    if (raddr == 5'd0) return 32'd0;
    return sel ? byData : rfData;
  endfunction

  always_comb begin
    hazard1 = srcHazard(ren1_p0, raddr1_p0, exe_valid, exe_wen, exe_ready, exe_waddr,
                        mem_valid, mem_wen, mem_ready, mem_waddr);
    hazard2 = srcHazard(ren2_p0, raddr2_p0, exe_valid, exe_wen, exe_ready, exe_waddr,
                        mem_valid, mem_wen, mem_ready, mem_waddr);
  end

  assign stall      = dsVld_p0 & (hazard1 | hazard2);
  assign readyGo    = ~stall;
  assign out_valid  = dsVld_p0 & readyGo & ~flush;
  assign in_allowin = ~dsVld_p0 | (readyGo & out_allowin);

  assign rf_raddr1   = raddr1_p0;
  assign rf_raddr2   = raddr2_p0;
  assign by_raddr1   = raddr1_p0;
  assign by_raddr2   = raddr2_p0;
  assign by_ren1     = ren1_p0;
  assign by_ren2     = ren2_p0;
  assign out_src1    = selOperand(raddr1_p0, by_sel[0], by_rdata1, rf_rdata1);
  assign out_src2    = selOperand(raddr2_p0, by_sel[1], by_rdata2, rf_rdata2);
  assign out_payload = payload_p0;

  // ---- decode -> operand-fetch stage register ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dsVld_p0   <= 1'b0;
      raddr1_p0  <= '0;
      raddr2_p0  <= '0;
      ren1_p0    <= 1'b0;
      ren2_p0    <= 1'b0;
      payload_p0 <= '0;
    end else if (flush) begin
      dsVld_p0 <= 1'b0;
    end else if (in_allowin) begin
      dsVld_p0 <= in_valid;
      if (in_valid) begin
        raddr1_p0  <= in_raddr1;
        raddr2_p0  <= in_raddr2;
        ren1_p0    <= in_ren1;
        ren2_p0    <= in_ren2;
        payload_p0 <= in_payload;
      end
    end
  end

`ifdef OPFETCH_STALL_CNT_EN
  logic [31:0] stallCnt_p0;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stallCnt_p0 <= '0;
    end else if (stall && !flush) begin
      stallCnt_p0 <= satInc(stallCnt_p0);
    end
  end

  assign stall_cnt = stallCnt_p0;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: reset, operand selection, interlocks, back-pressure, flush.
module tb_id_operand_stage;

`ifdef OPFETCH_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk, resetn, flush, in_valid, in_allowin;
  logic [4:0]  in_raddr1, in_raddr2;
  logic        in_ren1, in_ren2;
  logic [63:0] in_payload;
  logic [4:0]  rf_raddr1, rf_raddr2, by_raddr1, by_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2, by_rdata1, by_rdata2;
  logic        by_ren1, by_ren2;
  logic [1:0]  by_sel;
  logic        exe_valid, exe_wen, exe_ready, mem_valid, mem_wen, mem_ready;
  logic [4:0]  exe_waddr, mem_waddr;
  logic        out_valid, out_allowin;
  logic [31:0] out_src1, out_src2, stall_cnt;
  logic [63:0] out_payload;

  int tests = 0;
  int failed = 0;

  id_operand_stage #(.PAYLOAD_W(64)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_allowin(in_allowin),
    .in_raddr1(in_raddr1), .in_raddr2(in_raddr2),
    .in_ren1(in_ren1), .in_ren2(in_ren2), .in_payload(in_payload),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .by_raddr1(by_raddr1), .by_raddr2(by_raddr2),
    .by_ren1(by_ren1), .by_ren2(by_ren2),
    .by_rdata1(by_rdata1), .by_rdata2(by_rdata2), .by_sel(by_sel),
    .exe_valid(exe_valid), .exe_wen(exe_wen), .exe_ready(exe_ready), .exe_waddr(exe_waddr),
    .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_ready(mem_ready), .mem_waddr(mem_waddr),
    .out_valid(out_valid), .out_allowin(out_allowin),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_payload(out_payload), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    flush = 0; in_valid = 0; in_raddr1 = 0; in_raddr2 = 0; in_ren1 = 0; in_ren2 = 0;
    in_payload = 0; rf_rdata1 = 0; rf_rdata2 = 0; by_rdata1 = 0; by_rdata2 = 0; by_sel = 0;
    exe_valid = 0; exe_wen = 0; exe_ready = 0; exe_waddr = 0;
    mem_valid = 0; mem_wen = 0; mem_ready = 0; mem_waddr = 0; out_allowin = 1;
  endtask

  task automatic test_reset;
    resetn = 0;
    clear_inputs();
    #2;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    tests++; if (in_allowin !== 1'b1) begin failed++; $display("FAIL rst_in_allowin got %b want 1", in_allowin); end
    tests++; if (stall_cnt !== 32'd0) begin failed++; $display("FAIL rst_stall_cnt got %h want 0", stall_cnt); end
    tests++; if (out_src1 !== 32'd0 || out_src2 !== 32'd0) begin failed++; $display("FAIL rst_src got %h/%h want 0/0", out_src1, out_src2); end
    tests++; if (by_ren1 !== 1'b0 || by_ren2 !== 1'b0) begin failed++; $display("FAIL rst_by_ren got %b%b want 00", by_ren1, by_ren2); end
    #1 resetn = 1;
  endtask

  task automatic test_basic;
    step();
    in_valid = 1; in_raddr1 = 5; in_ren1 = 1; rf_rdata1 = 32'h1234; by_sel = 0; in_payload = 64'hA5;
    step();
    in_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid got %b want 1", out_valid); end
    tests++; if (out_src1 !== 32'h1234) begin failed++; $display("FAIL basic_src1 got %h want 1234", out_src1); end
    tests++; if (rf_raddr1 !== 5'd5 || by_raddr1 !== 5'd5 || by_ren1 !== 1'b1) begin failed++; $display("FAIL basic_addr got %0d/%0d/%b want 5/5/1", rf_raddr1, by_raddr1, by_ren1); end
    tests++; if (out_payload !== 64'hA5) begin failed++; $display("FAIL basic_payload got %h want a5", out_payload); end
    step();
    #2;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    in_valid = 1; in_raddr1 = 0; in_ren1 = 0; in_raddr2 = 7; in_ren2 = 1; in_payload = 64'h11;
    by_sel = 2'b10; by_rdata2 = 32'hCAFE; rf_rdata2 = 32'h1; rf_rdata1 = 32'h77; by_rdata1 = 32'h88;
    step();
    in_raddr2 = 0; in_payload = 64'h22;
    #2;
    tests++; if (out_valid !== 1'b1 || out_src2 !== 32'hCAFE) begin failed++; $display("FAIL byp_src2 got %b/%h want 1/cafe", out_valid, out_src2); end
    tests++; if (out_src1 !== 32'd0) begin failed++; $display("FAIL r0_src1 got %h want 0", out_src1); end
    tests++; if (in_allowin !== 1'b1) begin failed++; $display("FAIL b2b_allowin got %b want 1", in_allowin); end
    step();
    in_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b1 || out_src2 !== 32'd0) begin failed++; $display("FAIL r0_src2 got %b/%h want 1/0", out_valid, out_src2); end
    tests++; if (out_payload !== 64'h22) begin failed++; $display("FAIL b2b_payload got %h want 22", out_payload); end
    step();
    by_sel = 0;
  endtask

  task automatic test_load_use;
    in_valid = 1; in_raddr1 = 5; in_ren1 = 1; in_raddr2 = 0; in_ren2 = 0; in_payload = 64'h33;
    exe_valid = 1; exe_wen = 1; exe_waddr = 5; exe_ready = 0;
    by_sel = 0; by_rdata1 = 32'hBEEF; rf_rdata1 = 32'h5555;
    step();
    in_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin failed++; $display("FAIL lu_stall1 got v=%b a=%b want 0/0", out_valid, in_allowin); end
    step();
    #2;
    tests++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin failed++; $display("FAIL lu_stall2 got v=%b a=%b want 0/0", out_valid, in_allowin); end
    tests++; if (stall_cnt !== (CNT_EN ? 32'd1 : 32'd0)) begin failed++; $display("FAIL lu_cnt1 got %0d want %0d", stall_cnt, CNT_EN ? 1 : 0); end
    step();
    exe_ready = 1; by_sel = 2'b01;
    #2;
    tests++; if (out_valid !== 1'b1 || out_src1 !== 32'hBEEF) begin failed++; $display("FAIL lu_issue got %b/%h want 1/beef", out_valid, out_src1); end
    tests++; if (stall_cnt !== (CNT_EN ? 32'd2 : 32'd0)) begin failed++; $display("FAIL lu_cnt2 got %0d want %0d", stall_cnt, CNT_EN ? 2 : 0); end
    step();
    exe_valid = 0; exe_ready = 0; by_sel = 0;
  endtask

  task automatic test_exe_over_mem;
    in_valid = 1; in_raddr1 = 0; in_ren1 = 0; in_raddr2 = 9; in_ren2 = 1; in_payload = 64'h44;
    exe_valid = 1; exe_wen = 1; exe_waddr = 9; exe_ready = 0;
    mem_valid = 1; mem_wen = 1; mem_waddr = 9; mem_ready = 1;
    rf_rdata2 = 32'h99;
    step();
    in_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin failed++; $display("FAIL em_stall got v=%b a=%b want 0/0", out_valid, in_allowin); end
    step();
    exe_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b1 || out_src2 !== 32'h99) begin failed++; $display("FAIL em_release got %b/%h want 1/99", out_valid, out_src2); end
    tests++; if (stall_cnt !== (CNT_EN ? 32'd3 : 32'd0)) begin failed++; $display("FAIL em_cnt got %0d want %0d", stall_cnt, CNT_EN ? 3 : 0); end
    step();
    mem_valid = 0; mem_ready = 0;
  endtask

  task automatic test_backpressure;
    out_allowin = 0;
    in_valid = 1; in_raddr1 = 3; in_ren1 = 1; in_raddr2 = 0; in_ren2 = 0; in_payload = 64'h5151; rf_rdata1 = 32'h33;
    step();
    in_payload = 64'h6262; in_raddr1 = 4;
    #2;
    tests++; if (out_valid !== 1'b1 || in_allowin !== 1'b0) begin failed++; $display("FAIL bp_hold got v=%b a=%b want 1/0", out_valid, in_allowin); end
    step();
    #2;
    tests++; if (out_payload !== 64'h5151 || out_src1 !== 32'h33) begin failed++; $display("FAIL bp_stable got %h/%h want 5151/33", out_payload, out_src1); end
    flush = 1;
    #1;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_flush_comb got %b want 0", out_valid); end
    step();
    flush = 0; in_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b0 || in_allowin !== 1'b1) begin failed++; $display("FAIL bp_flushed got v=%b a=%b want 0/1", out_valid, in_allowin); end
    out_allowin = 1;
  endtask

  task automatic test_flush_incoming;
    in_valid = 1; flush = 1; in_raddr1 = 6; in_ren1 = 1; in_payload = 64'h77;
    step();
    flush = 0; in_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b0 || in_allowin !== 1'b1) begin failed++; $display("FAIL fl_in got v=%b a=%b want 0/1", out_valid, in_allowin); end
  endtask

  task automatic test_reset_midstall;
    step();
    in_valid = 1; in_raddr1 = 4; in_ren1 = 1; exe_valid = 1; exe_wen = 1; exe_waddr = 4; exe_ready = 0;
    step();
    in_valid = 0;
    #2;
    tests++; if (out_valid !== 1'b0 || in_allowin !== 1'b0) begin failed++; $display("FAIL rm_stall got v=%b a=%b want 0/0", out_valid, in_allowin); end
    #1 resetn = 0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_allowin !== 1'b1) begin failed++; $display("FAIL rm_async got v=%b a=%b want 0/1", out_valid, in_allowin); end
    tests++; if (stall_cnt !== 32'd0 || by_ren1 !== 1'b0) begin failed++; $display("FAIL rm_clear got cnt=%0d ren=%b want 0/0", stall_cnt, by_ren1); end
    #1 resetn = 1;
    exe_valid = 0;
    step();
    #2;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rm_no_out got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_load_use();
    test_exe_over_mem();
    test_backpressure();
    test_flush_incoming();
    test_reset_midstall();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
